// File: rtl/mdio_phy_responder.sv
// -----------------------------------------------------------------------------
// mdio_phy_responder
//
// Clause-22 MDIO management responder (PHY side). It holds a 32x16 register
// file and serves read and write frames that arrive on phy_mdc/mdio_in.
// phy_mdc is oversampled by clk, so the whole block runs in the clk domain.
//
// Ports
//   clk          system clock, at least 4x the phy_mdc frequency
//   reset        asynchronous active-low reset
//   phy_mdc      management clock from the initiator
//   mdio_in      MDIO pad input
//   mdio_out     MDIO drive value
//   mdio_oen     active-low output enable for the MDIO pad
//   reg_wr_valid one-clk pulse when a write commits to the register file
//   reg_wr_addr  register address of the committed write
//   reg_wr_data  stored data of the committed write
//   frame_active high from start-of-frame detection until the end of the frame
// -----------------------------------------------------------------------------
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR    = 5'd1,
    parameter logic [15:0] PHY_ID1     = 16'h0022,
    parameter logic [15:0] PHY_ID2     = 16'h1622,
    parameter logic [15:0] REG0_RST    = 16'h1000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phy_mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic        reg_wr_valid,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
    output logic        frame_active
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ST2   = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_DATA  = 3'd6
    } state_t;

    // Power-on / self-clear value of each register. Registers 2 and 3 hold
    // the PHY identifier and are never written.
    function automatic logic [15:0] reg_reset_val(input logic [4:0] a);
        logic [15:0] v;
        case (a)
            5'd0:    v = REG0_RST;
            5'd2:    v = PHY_ID1;
            5'd3:    v = PHY_ID2;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------ sync
    logic [SYNC_STAGES-1:0] mdc_sync_q;
    logic [SYNC_STAGES-1:0] mdio_sync_q;
    logic                   prev_mdc_q;
    logic                   mdc_s;
    logic                   mdio_s;
    logic                   rise_s;
    logic                   fall_s;

    // Synchroniser chains for MDC and MDIO (equal depth keeps them aligned)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '1;
            prev_mdc_q  <= 1'b0;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], phy_mdc};
            mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_in};
            prev_mdc_q  <= mdc_sync_q[SYNC_STAGES-1];
        end
    end

    assign mdc_s  = mdc_sync_q[SYNC_STAGES-1];
    assign mdio_s = mdio_sync_q[SYNC_STAGES-1];
    assign rise_s = mdc_s & ~prev_mdc_q;
    assign fall_s = ~mdc_s & prev_mdc_q;

    // ------------------------------------------------------------ registers
    state_t      state_q,        state_d;
    logic [5:0]  pre_cnt_q,      pre_cnt_d;
    logic [4:0]  bit_cnt_q,      bit_cnt_d;
    logic        is_read_q,      is_read_d;
    logic        op_bit_q,       op_bit_d;
    logic [4:0]  phyad_q,        phyad_d;
    logic [4:0]  regad_q,        regad_d;
    logic [15:0] shift_q,        shift_d;
    logic        mdio_out_q,     mdio_out_d;
    logic        mdio_oen_q,     mdio_oen_d;
    logic        wr_valid_q,     wr_valid_d;
    logic [4:0]  wr_addr_q,      wr_addr_d;
    logic [15:0] wr_data_q,      wr_data_d;
    logic        frame_active_q, frame_active_d;

    logic [15:0] regs_q [0:31];

    logic        commit_s;
    logic        self_clear_s;
    logic [15:0] rd_data_s;
    logic [15:0] wdata_s;
    logic [15:0] store_data_s;
    logic        read_only_s;

    // Value to return is taken with the last REGAD bit still in flight
    assign rd_data_s    = regs_q[{regad_q[3:0], mdio_s}];
    assign wdata_s      = {shift_q[14:0], mdio_s};
    assign read_only_s  = (regad_q == 5'd2) || (regad_q == 5'd3);
    assign self_clear_s = (regad_q == 5'd0) && wdata_s[15];
    // Control bit 15 is self-clearing, so it is never stored
    assign store_data_s = (regad_q == 5'd0) ? {1'b0, wdata_s[14:0]} : wdata_s;

    // Frame state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            pre_cnt_q      <= 6'd0;
            bit_cnt_q      <= 5'd0;
            is_read_q      <= 1'b0;
            op_bit_q       <= 1'b0;
            phyad_q        <= 5'd0;
            regad_q        <= 5'd0;
            shift_q        <= 16'h0000;
            mdio_out_q     <= 1'b1;
            mdio_oen_q     <= 1'b1;
            wr_valid_q     <= 1'b0;
            wr_addr_q      <= 5'd0;
            wr_data_q      <= 16'h0000;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pre_cnt_q      <= pre_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            is_read_q      <= is_read_d;
            op_bit_q       <= op_bit_d;
            phyad_q        <= phyad_d;
            regad_q        <= regad_d;
            shift_q        <= shift_d;
            mdio_out_q     <= mdio_out_d;
            mdio_oen_q     <= mdio_oen_d;
            wr_valid_q     <= wr_valid_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            frame_active_q <= frame_active_d;
        end
    end

    // Register file; a self-clearing control write restores all RW registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= reg_reset_val(5'(i));
            end
        end else if (commit_s) begin
            if (self_clear_s) begin
                for (int i = 0; i < 32; i++) begin
                    regs_q[i] <= reg_reset_val(5'(i));
                end
                regs_q[0] <= store_data_s;
            end else begin
                regs_q[regad_q] <= store_data_s;
            end
        end
    end

    // Next-state and output logic: bits sampled on MDC rise, pad changes on fall
    always_comb begin
        state_d        = state_q;
        pre_cnt_d      = pre_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        is_read_d      = is_read_q;
        op_bit_d       = op_bit_q;
        phyad_d        = phyad_q;
        regad_d        = regad_q;
        shift_d        = shift_q;
        mdio_out_d     = mdio_out_q;
        mdio_oen_d     = mdio_oen_q;
        wr_valid_d     = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        frame_active_d = frame_active_q;
        commit_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise_s) begin
                    if (mdio_s) begin
                        // Count preamble ones, saturating at 32
                        if (pre_cnt_q != 6'd32) begin
                            pre_cnt_d = pre_cnt_q + 6'd1;
                        end else begin
                            pre_cnt_d = pre_cnt_q;
                        end
                    end else begin
                        pre_cnt_d = 6'd0;
                        if (pre_cnt_q == 6'd32) begin
                            state_d        = S_ST2;
                            frame_active_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ST2: begin
                if (rise_s) begin
                    if (mdio_s) begin
                        state_d   = S_OP;
                        bit_cnt_d = 5'd0;
                    end else begin
                        state_d        = S_IDLE;
                        pre_cnt_d      = 6'd0;
                        frame_active_d = 1'b0;
                    end
                end else begin
                    state_d = S_ST2;
                end
            end

            S_OP: begin
                if (rise_s) begin
                    if (bit_cnt_q == 5'd0) begin
                        op_bit_d  = mdio_s;
                        bit_cnt_d = 5'd1;
                    end else begin
                        bit_cnt_d = 5'd0;
                        case ({op_bit_q, mdio_s})
                            2'b10: begin
                                is_read_d = 1'b1;
                                state_d   = S_PHYAD;
                            end
                            2'b01: begin
                                is_read_d = 1'b0;
                                state_d   = S_PHYAD;
                            end
                            default: begin
                                state_d        = S_IDLE;
                                pre_cnt_d      = 6'd0;
                                frame_active_d = 1'b0;
                            end
                        endcase
                    end
                end else begin
                    state_d = S_OP;
                end
            end

            S_PHYAD: begin
                if (rise_s) begin
                    phyad_d = {phyad_q[3:0], mdio_s};
                    if (bit_cnt_q == 5'd4) begin
                        state_d   = S_REGAD;
                        bit_cnt_d = 5'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    state_d = S_PHYAD;
                end
            end

            S_REGAD: begin
                if (rise_s) begin
                    regad_d = {regad_q[3:0], mdio_s};
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = 5'd0;
                        if (phyad_q != PHY_ADDR) begin
                            // Not addressed to us: drop silently, never drive
                            state_d        = S_IDLE;
                            pre_cnt_d      = 6'd0;
                            frame_active_d = 1'b0;
                        end else begin
                            state_d = S_TA;
                            if (is_read_q) begin
                                shift_d = rd_data_s;
                            end else begin
                                shift_d = shift_q;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    state_d = S_REGAD;
                end
            end

            S_TA: begin
                if (rise_s) begin
                    if (is_read_q) begin
                        // First TA bit is high-Z; we start driving on the next fall
                        state_d   = S_DATA;
                        bit_cnt_d = 5'd0;
                    end else if (bit_cnt_q == 5'd1) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 5'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    state_d = S_TA;
                end
            end

            S_DATA: begin
                if (is_read_q) begin
                    // Fall 0 drives TA bit 2, falls 1..16 drive D15..D0, fall 17 releases
                    if (fall_s) begin
                        if (bit_cnt_q == 5'd0) begin
                            mdio_oen_d = 1'b0;
                            mdio_out_d = 1'b0;
                            bit_cnt_d  = 5'd1;
                        end else if (bit_cnt_q == 5'd17) begin
                            mdio_oen_d     = 1'b1;
                            mdio_out_d     = 1'b1;
                            state_d        = S_IDLE;
                            pre_cnt_d      = 6'd0;
                            frame_active_d = 1'b0;
                        end else begin
                            mdio_out_d = shift_q[15];
                            shift_d    = {shift_q[14:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    if (rise_s) begin
                        shift_d = wdata_s;
                        if (bit_cnt_q == 5'd15) begin
                            if (read_only_s) begin
                                commit_s = 1'b0;
                            end else begin
                                commit_s   = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = regad_q;
                                wr_data_d  = store_data_s;
                            end
                            state_d        = S_IDLE;
                            pre_cnt_d      = 6'd0;
                            frame_active_d = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            default: begin
                state_d        = S_IDLE;
                pre_cnt_d      = 6'd0;
                mdio_oen_d     = 1'b1;
                mdio_out_d     = 1'b1;
                frame_active_d = 1'b0;
            end
        endcase
    end

    assign mdio_out     = mdio_out_q;
    assign mdio_oen     = mdio_oen_q;
    assign reg_wr_valid = wr_valid_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign frame_active = frame_active_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// -----------------------------------------------------------------------------
// tb_mdio_phy_responder
//
// Acts as the MDIO initiator: generates MDC from clk, drives frames bit by
// bit and reads back the responder's drive late in each MDC high phase.
// Expected values come from a register-level model of the PHY register map.
// -----------------------------------------------------------------------------
module tb_mdio_phy_responder;

    localparam logic [4:0]  PHY_ADDR = 5'd1;
    localparam logic [15:0] PHY_ID1  = 16'h0022;
    localparam logic [15:0] PHY_ID2  = 16'h1622;
    localparam logic [15:0] REG0_RST = 16'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        phy_mdc;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oen;
    logic        reg_wr_valid;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        frame_active;

    mdio_phy_responder dut (
        .clk          (clk),
        .reset        (reset),
        .phy_mdc      (phy_mdc),
        .mdio_in      (mdio_in),
        .mdio_out     (mdio_out),
        .mdio_oen     (mdio_oen),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .frame_active (frame_active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int half  = 2;      // MDC half period in clk cycles
    int oen_low = 0;    // MDC periods in which the responder drove the pad

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------- register map model
    logic [15:0] mregs [32];

    function automatic logic [15:0] rst_val(input int a);
        return (a == 0) ? REG0_RST : 16'h0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = rst_val(i);
    endtask

    function automatic logic [15:0] model_read(input logic [4:0] a);
        if (a == 5'd2) return PHY_ID1;
        if (a == 5'd3) return PHY_ID2;
        return mregs[a];
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [15:0] d);
        if (a == 5'd2 || a == 5'd3) return;
        if (a == 5'd0 && d[15]) begin
            for (int i = 0; i < 32; i++) mregs[i] = rst_val(i);
            mregs[0] = {1'b0, d[14:0]};
        end else begin
            mregs[a] = d;
        end
    endtask

    // ------------------------------------------------- write pulse monitor
    logic [20:0] pulses[$];
    int          width_err = 0;
    logic        prev_v = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_v = 1'b0;
        end else begin
            if (reg_wr_valid) begin
                pulses.push_back({reg_wr_addr, reg_wr_data});
                if (prev_v) width_err++;
            end
            prev_v = reg_wr_valid;
        end
    end

    // ------------------------------------------------- MDC bit engine
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One MDC period: drive bit while low, sample responder late in high phase
    task automatic mdc_bit(input logic b, output logic so, output logic soen);
        mdio_in = b;
        tick(half);
        phy_mdc = 1'b1;
        tick(half);
        so   = mdio_out;
        soen = mdio_oen;
        if (!soen) oen_low++;
        phy_mdc = 1'b0;
    endtask

    task automatic send_hdr(input int pre, input logic [1:0] op, input logic [4:0] pa,
                            input logic [4:0] ra);
        logic so, soen;
        mdc_bit(1'b0, so, soen);   // clears any leftover preamble count
        repeat (pre) mdc_bit(1'b1, so, soen);
        mdc_bit(1'b0, so, soen);
        mdc_bit(1'b1, so, soen);
        mdc_bit(op[1], so, soen);
        mdc_bit(op[0], so, soen);
        for (int i = 4; i >= 0; i--) mdc_bit(pa[i], so, soen);
        for (int i = 4; i >= 0; i--) mdc_bit(ra[i], so, soen);
    endtask

    // Complete frame plus model update and checks
    task automatic run_frame(input string tag, input int pre, input logic [1:0] op,
                             input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        logic        so, soen, ta_bit, fa_mid, valid;
        logic [15:0] rd;
        int          exp_n;
        rd = 16'h0000;
        valid = (pre >= 32) && (op == 2'b10 || op == 2'b01) && (pa == PHY_ADDR);
        pulses.delete();
        oen_low = 0;
        send_hdr(pre, op, pa, ra);
        if (op == 2'b10) begin
            mdc_bit(1'b1, so, soen);
            mdc_bit(1'b1, so, soen);
            ta_bit = so;
            fa_mid = frame_active;
            for (int i = 0; i < 16; i++) begin
                mdc_bit(1'b1, so, soen);
                rd = {rd[14:0], so};
            end
        end else begin
            mdc_bit(1'b1, so, soen);
            mdc_bit(1'b0, so, soen);
            ta_bit = 1'b0;
            fa_mid = frame_active;
            for (int i = 15; i >= 0; i--) mdc_bit(wd[i], so, soen);
        end
        mdc_bit(1'b1, so, soen);
        mdc_bit(1'b1, so, soen);

        if (valid && op == 2'b10) begin
            check({tag, "_rdata"}, rd, model_read(ra));
            check({tag, "_ta"}, ta_bit, 1'b0);
            check({tag, "_drive_len"}, oen_low, 17);
            check({tag, "_fa_mid"}, fa_mid, 1'b1);
        end else begin
            check({tag, "_no_drive"}, oen_low, 0);
        end
        check({tag, "_oen_end"}, mdio_oen, 1'b1);
        check({tag, "_fa_end"}, frame_active, 1'b0);

        exp_n = (valid && op == 2'b01 && ra != 5'd2 && ra != 5'd3) ? 1 : 0;
        check({tag, "_pulses"}, pulses.size(), exp_n);
        if (exp_n == 1 && pulses.size() == 1) begin
            check({tag, "_wr_addr"}, pulses[0][20:16], ra);
            if (!(ra == 5'd0 && wd[15])) check({tag, "_wr_data"}, pulses[0][15:0], wd);
        end
        if (valid && op == 2'b01) model_write(ra, wd);
    endtask

    // ------------------------------------------------- stimulus
    initial begin : main
        logic        so, soen;
        logic [7:0]  hi;
        logic [1:0]  ops [6];
        int          pre;
        logic [1:0]  op;
        logic [4:0]  pa;

        ops[0] = 2'b10; ops[1] = 2'b01; ops[2] = 2'b10;
        ops[3] = 2'b01; ops[4] = 2'b00; ops[5] = 2'b11;

        reset   = 1'b0;
        phy_mdc = 1'b0;
        mdio_in = 1'b1;
        tick(3);
        check("rst_oen", mdio_oen, 1'b1);
        check("rst_out", mdio_out, 1'b1);
        check("rst_wr_valid", reg_wr_valid, 1'b0);
        check("rst_wr_addr", reg_wr_addr, 5'd0);
        check("rst_wr_data", reg_wr_data, 16'h0000);
        check("rst_fa", frame_active, 1'b0);
        reset = 1'b1;
        tick(2);
        model_reset();

        // Write then read at 4x oversampling
        half = 2;
        run_frame("wr4", 32, 2'b01, PHY_ADDR, 5'd4, 16'hA5C3);
        run_frame("rd4", 32, 2'b10, PHY_ADDR, 5'd4, 16'h0000);

        // Identifier and read-only registers
        run_frame("rd_id1", 32, 2'b10, PHY_ADDR, 5'd2, 16'h0000);
        run_frame("wr_id2", 32, 2'b01, PHY_ADDR, 5'd3, 16'hFFFF);
        run_frame("rd_id2", 32, 2'b10, PHY_ADDR, 5'd3, 16'h0000);

        // Foreign and malformed frames, then a normal one
        run_frame("foreign", 32, 2'b10, 5'd7, 5'd4, 16'h0000);
        run_frame("short_pre", 31, 2'b10, PHY_ADDR, 5'd4, 16'h0000);
        run_frame("short_wr", 31, 2'b01, PHY_ADDR, 5'd4, 16'h5555);
        run_frame("op11", 32, 2'b11, PHY_ADDR, 5'd4, 16'h1111);
        run_frame("op00", 32, 2'b00, PHY_ADDR, 5'd4, 16'h2222);
        run_frame("rd4_again", 32, 2'b10, PHY_ADDR, 5'd4, 16'h0000);

        // Self-clearing control write
        run_frame("wr5", 32, 2'b01, PHY_ADDR, 5'd5, 16'h1234);
        run_frame("wr0_sc", 32, 2'b01, PHY_ADDR, 5'd0, 16'h8000);
        run_frame("rd5_sc", 32, 2'b10, PHY_ADDR, 5'd5, 16'h0000);
        run_frame("rd0_sc", 32, 2'b10, PHY_ADDR, 5'd0, 16'h0000);
        run_frame("rd4_sc", 32, 2'b10, PHY_ADDR, 5'd4, 16'h0000);

        // Reset during D7 of a read of register 0
        run_frame("wr0", 32, 2'b01, PHY_ADDR, 5'd0, 16'h0ABC);
        oen_low = 0;
        send_hdr(32, 2'b10, PHY_ADDR, 5'd0);
        mdc_bit(1'b1, so, soen);
        mdc_bit(1'b1, so, soen);
        hi = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mdc_bit(1'b1, so, soen);
            hi = {hi[6:0], so};
        end
        check("mid_rd_hi", hi, mregs[0][15:8]);
        mdio_in = 1'b1;
        tick(half);
        phy_mdc = 1'b1;
        tick(1);
        check("mid_rd_oen", mdio_oen, 1'b0);
        reset = 1'b0;
        #1;
        check("abort_oen", mdio_oen, 1'b1);
        check("abort_out", mdio_out, 1'b1);
        check("abort_fa", frame_active, 1'b0);
        phy_mdc = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        model_reset();
        run_frame("rd0_after_rst", 32, 2'b10, PHY_ADDR, 5'd0, 16'h0000);

        // Randomized frames at varied oversampling ratios
        for (int n = 0; n < 40; n++) begin
            half = $urandom_range(2, 4);
            pre  = ($urandom_range(0, 7) == 0) ? 31 : 32 + $urandom_range(0, 2);
            op   = ops[$urandom_range(0, 5)];
            pa   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : PHY_ADDR;
            run_frame($sformatf("rnd%0d", n), pre, op, pa, 5'($urandom_range(0, 31)),
                      16'($urandom));
        end

        check("pulse_width", width_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
